pio_irq_ctrl: RTL and testbench

PIO_IRQ_CTRL -- requirements
Module: pio_irq_ctrl

---
 rtl/pio_pkg.sv | 23 ++
 rtl/pio_sync_edge.sv | 34 +++
 rtl/pio_irq_ctrl.sv | 153 +++++++++++++++
 tb/tb_pio_irq_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO interrupt controller: register indices,
// pending-source bit positions, debounce counter width and the write-capture record.
`timescale 1ns/1ps
package pio_pkg;

   localparam logic REG_PEND = 1'b0;
   localparam logic REG_MASK = 1'b1;

   localparam int BIT_CH   = 0;
   localparam int BIT_SOFT = 1;
   localparam int BIT_CONN = 2;
   localparam int BIT_DISC = 3;

   localparam int DB_W = 16;

   // Snapshot of the bus taken while the synchronised write strobe is low
   typedef struct packed {
      logic       sel;
      logic       a0;
      logic [3:0] data;
   } wr_cap_t;

endpackage

// File: rtl/pio_sync_edge.sv
// 2-flop synchroniser plus one history flop for edge pulses. Every flop
// presets to RST_LVL so a line idling at its reset level produces no edge.
`timescale 1ns/1ps
module pio_sync_edge #(
   parameter logic RST_LVL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic s1, s2, s3;

   // Metastability chain followed by the previous-value flop for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= RST_LVL;
         s2 <= RST_LVL;
         s3 <= RST_LVL;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync = s2;
   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

endmodule

// File: rtl/pio_irq_ctrl.sv
// PIO interrupt controller: latches CH375 / soft-button / cable events into
// PEND, masks them with MASK and drives the active-low nIN10 line.
// Optional build macro PIO_IRQ_DEBOUNCE_EN adds a 16-bit stability filter on SOFT.
`timescale 1ns/1ps
module pio_irq_ctrl
   import pio_pkg::*;
(
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       SEL,
   input  logic       A0,
   input  logic       nWR,
   input  logic       nRD,
   input  logic [7:0] PD_IN,
   output logic [7:0] RD_DATA,
   output logic       RD_OE,
   input  logic       nIN_CH,
   input  logic       SOFT,
   input  logic       FT_RST,
   output logic       nIN10
);

   logic ch_fall, ch_sync_unused, ch_rise_unused;
   logic soft_sync, soft_fall, soft_rise_unused;
   logic ft_rise, ft_fall, ft_sync_unused;
   logic wr_sync, wr_rise, wr_fall_unused;
   logic rd_sync_unused, rd_rise_unused, rd_fall_unused;
   logic [3:0] pd_hi_unused;

   pio_sync_edge #(.RST_LVL(1'b1)) u_ch (
      .clk(CLK), .rst(nRESET), .din(nIN_CH),
      .sync(ch_sync_unused), .rise(ch_rise_unused), .fall(ch_fall));

   pio_sync_edge #(.RST_LVL(1'b1)) u_soft (
      .clk(CLK), .rst(nRESET), .din(SOFT),
      .sync(soft_sync), .rise(soft_rise_unused), .fall(soft_fall));

   pio_sync_edge #(.RST_LVL(1'b0)) u_ft (
      .clk(CLK), .rst(nRESET), .din(FT_RST),
      .sync(ft_sync_unused), .rise(ft_rise), .fall(ft_fall));

   pio_sync_edge #(.RST_LVL(1'b1)) u_wr (
      .clk(CLK), .rst(nRESET), .din(nWR),
      .sync(wr_sync), .rise(wr_rise), .fall(wr_fall_unused));

   // The read strobe is synchronised for completeness; RD_OE uses the raw strobe
   pio_sync_edge #(.RST_LVL(1'b1)) u_rd (
      .clk(CLK), .rst(nRESET), .din(nRD),
      .sync(rd_sync_unused), .rise(rd_rise_unused), .fall(rd_fall_unused));

   assign pd_hi_unused = PD_IN[7:4];

   logic soft_evt;

`ifdef PIO_IRQ_DEBOUNCE_EN
   logic            soft_fall_unused;
   logic [DB_W-1:0] db_cnt;
   logic            db_lvl, db_prev;

   assign soft_fall_unused = soft_fall;

   // Debounced level flips only after 2^DB_W consecutive samples differing from it
   always_ff @(posedge CLK or posedge nRESET) begin
      if (nRESET) begin
         db_cnt  <= '0;
         db_lvl  <= 1'b1;
         db_prev <= 1'b1;
      end else begin
         db_prev <= db_lvl;
         if (soft_sync == db_lvl) begin
            db_cnt <= '0;
         end else if (&db_cnt) begin
            db_lvl <= soft_sync;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   assign soft_evt = db_prev & ~db_lvl;
`else
   logic soft_sync_unused;
   assign soft_sync_unused = soft_sync;
   assign soft_evt = soft_fall;
`endif

   logic [1:0] live_pipe;
   logic       wr_arm;
   wr_cap_t    cap;
   logic [3:0] pend, mask, src_set, pend_clr;
   logic       commit;

   // Arm writes only after the synchronised strobe has shown a real idle-high
   // sample since reset, so a write straddling reset release never commits.
   always_ff @(posedge CLK or posedge nRESET) begin
      if (nRESET) begin
         live_pipe <= 2'b00;
         wr_arm    <= 1'b0;
      end else begin
         live_pipe <= {live_pipe[0], 1'b1};
         wr_arm    <= wr_arm | (live_pipe[1] & wr_sync);
      end
   end

   // Track the bus on every cycle the synchronised write strobe is low
   always_ff @(posedge CLK or posedge nRESET) begin
      if (nRESET) begin
         cap <= '0;
      end else if (!wr_sync) begin
         cap.sel  <= SEL;
         cap.a0   <= A0;
         cap.data <= PD_IN[3:0];
      end
   end

   assign commit = wr_rise & wr_arm & cap.sel;

   // Source events and write-1-to-clear decode
   always_comb begin
      src_set           = '0;
      src_set[BIT_CH]   = ch_fall;
      src_set[BIT_SOFT] = soft_evt;
      src_set[BIT_CONN] = ft_rise;
      src_set[BIT_DISC] = ft_fall;
      pend_clr          = (commit && cap.a0 == REG_PEND) ? cap.data : 4'h0;
   end

   // PEND / MASK registers; a same-cycle set beats the clear
   always_ff @(posedge CLK or posedge nRESET) begin
      if (nRESET) begin
         pend <= '0;
         mask <= '0;
      end else begin
         pend <= (pend & ~pend_clr) | src_set;
         if (commit && cap.a0 == REG_MASK) mask <= cap.data;
      end
   end

   // Registered interrupt line and read data
   always_ff @(posedge CLK or posedge nRESET) begin
      if (nRESET) begin
         nIN10   <= 1'b1;
         RD_DATA <= '0;
      end else begin
         nIN10   <= ~|(pend & mask);
         RD_DATA <= (A0 == REG_MASK) ? {4'h0, mask} : {4'h0, pend};
      end
   end

   assign RD_OE = SEL & ~nRD;

endmodule

// File: tb/tb_pio_irq_ctrl.sv
// Directed bench for pio_irq_ctrl: expected values are queued as stimulus
// is applied and popped when the corresponding DUT output is sampled.
`timescale 1ns/1ps
module tb_pio_irq_ctrl;

   logic       CLK = 1'b0;
   logic       nRESET, SEL, A0, nWR, nRD, nIN_CH, SOFT, FT_RST;
   logic [7:0] PD_IN;
   logic [7:0] RD_DATA;
   logic       RD_OE, nIN10;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t exp_q[$];

   pio_irq_ctrl dut (
      .CLK(CLK), .nRESET(nRESET), .SEL(SEL), .A0(A0), .nWR(nWR), .nRD(nRD),
      .PD_IN(PD_IN), .RD_DATA(RD_DATA), .RD_OE(RD_OE),
      .nIN_CH(nIN_CH), .SOFT(SOFT), .FT_RST(FT_RST), .nIN10(nIN10));

   always #42 CLK = ~CLK;

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [7:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [7:0] obs);
      exp_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty observed=%h", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic wr(input logic sel, input logic a0, input logic [7:0] d);
      SEL = sel; A0 = a0; PD_IN = d;
      nWR = 1'b0;
      tick(4);
      nWR = 1'b1;
      tick(4);
      SEL = 1'b0;
   endtask

   task automatic rd(input logic a0, output logic [7:0] v);
      SEL = 1'b1; A0 = a0;
      nRD = 1'b0;
      tick(2);
      v = RD_DATA;
      nRD = 1'b1;
      SEL = 1'b0;
      tick(1);
   endtask

   initial begin
      logic [7:0] v;
      nRESET = 1'b1; SEL = 1'b0; A0 = 1'b0; nWR = 1'b1; nRD = 1'b1;
      PD_IN = 8'h00; nIN_CH = 1'b1; SOFT = 1'b1; FT_RST = 1'b0;

      // reset state
      tick(3);
      expect_val("rst_nin10", 8'h01);   check({7'b0, nIN10});
      expect_val("rst_rd_data", 8'h00); check(RD_DATA);
      expect_val("rst_rd_oe", 8'h00);   check({7'b0, RD_OE});
      nRESET = 1'b0;
      tick(4);

      // MASK=1, nIN_CH 200 ns pulse: nIN10 low exactly 4 edges later
      wr(1'b1, 1'b1, 8'h01);
      nIN_CH = 1'b0;
      fork begin #200 nIN_CH = 1'b1; end join_none
      tick(3);
      expect_val("ch_lat3_high", 8'h01); check({7'b0, nIN10});
      tick(1);
      expect_val("ch_lat4_low", 8'h00);  check({7'b0, nIN10});
      tick(4);
      rd(1'b0, v);
      expect_val("ch_pend", 8'h01);      check(v);

      // W1C bit0: nIN10 releases 2 edges after the synchronised rise
      SEL = 1'b1; A0 = 1'b0; PD_IN = 8'h01; nWR = 1'b0;
      tick(4);
      nWR = 1'b1;
      tick(3);
      expect_val("clr_still_low", 8'h00); check({7'b0, nIN10});
      tick(1);
      expect_val("clr_high", 8'h01);      check({7'b0, nIN10});
      tick(2);
      SEL = 1'b0;

      // cable connect/disconnect with MASK=0
      wr(1'b1, 1'b1, 8'h00);
      FT_RST = 1'b1; tick(6);
      FT_RST = 1'b0; tick(6);
      rd(1'b0, v);
      expect_val("ft_pend", 8'h0C);      check(v);
      expect_val("ft_nin10_high", 8'h01); check({7'b0, nIN10});
      wr(1'b1, 1'b1, 8'h08);
      tick(1);
      expect_val("disc_mask_low", 8'h00); check({7'b0, nIN10});

      // write with SEL=0 ignored, RD_OE follows raw strobe
      wr(1'b1, 1'b1, 8'h00);
      wr(1'b0, 1'b1, 8'hFF);
      SEL = 1'b1; A0 = 1'b1; nRD = 1'b1;
      tick(2);
      expect_val("oe_before", 8'h00);    check({7'b0, RD_OE});
      nRD = 1'b0; #1;
      expect_val("oe_during", 8'h01);    check({7'b0, RD_OE});
      tick(2);
      expect_val("sel0_mask", 8'h00);    check(RD_DATA);
      nRD = 1'b1; #1;
      expect_val("oe_after", 8'h00);     check({7'b0, RD_OE});
      SEL = 1'b0;
      tick(1);

      // nIN_CH edge and W1C of bit0 land in the same cycle: set wins
      SEL = 1'b1; A0 = 1'b0; PD_IN = 8'h01; nWR = 1'b0;
      tick(4);
      nWR = 1'b1; nIN_CH = 1'b0;
      tick(5);
      nIN_CH = 1'b1; SEL = 1'b0;
      tick(4);
      rd(1'b0, v);
      expect_val("collide_pend", 8'h0D); check(v);

      // soft button
`ifdef PIO_IRQ_DEBOUNCE_EN
      SOFT = 1'b0; tick(11905);
      SOFT = 1'b1; tick(6);
      rd(1'b0, v);
      expect_val("soft_glitch_filtered", 8'h0D); check(v);
      SOFT = 1'b0; tick(71429);
      rd(1'b0, v);
      expect_val("soft_hold_set", 8'h0F); check(v);
      SOFT = 1'b1; tick(4);
`else
      SOFT = 1'b0; tick(11905);
      SOFT = 1'b1; tick(6);
      rd(1'b0, v);
      expect_val("soft_glitch_set", 8'h0F); check(v);
`endif

      // reset during a write: everything cleared, interrupted write discarded
      wr(1'b1, 1'b1, 8'h0F);
      tick(1);
      expect_val("all_mask_low", 8'h00); check({7'b0, nIN10});
      SEL = 1'b1; A0 = 1'b1; PD_IN = 8'h05; nWR = 1'b0;
      tick(4);
      nRESET = 1'b1;
      tick(2);
      expect_val("midrst_nin10", 8'h01);   check({7'b0, nIN10});
      expect_val("midrst_rd_data", 8'h00); check(RD_DATA);
      nRESET = 1'b0;
      tick(4);
      nWR = 1'b1;
      tick(6);
      rd(1'b1, v);
      expect_val("post_rst_mask", 8'h00);  check(v);
      rd(1'b0, v);
      expect_val("post_rst_pend", 8'h00);  check(v);
      expect_val("post_rst_nin10", 8'h01); check({7'b0, nIN10});

      // writes work again afterwards
      wr(1'b1, 1'b1, 8'h03);
      rd(1'b1, v);
      expect_val("rearm_mask", 8'h03);     check(v);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
